// File: rtl/fetch_queue.sv
// Instruction fetch queue: a single-outstanding memory fetch engine feeding a
// first-word-fall-through FIFO of {pc, instr} entries, with redirect/flush.
module fetch_queue #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int DEPTH    = 4,
   parameter int PC_STEP  = 2,
   parameter int RESET_PC = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     redirect,
   input  logic [ADDR_W-1:0]        redirect_addr,
   output logic                     mem_re,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic                     mem_ack,
   input  logic [DATA_W-1:0]        mem_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        instr_out,
   output logic [ADDR_W-1:0]        pc_out,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   fetch_pc;
   logic [ADDR_W-1:0]   pc_inc;
   logic [PW-1:0]       rd_ptr, wr_ptr;
   logic [CW-1:0]       cnt_q, cnt_next;
   logic                push, pop;

   logic [DATA_W-1:0]   instr_mem [DEPTH];
   logic [ADDR_W-1:0]   pc_mem    [DEPTH];

   assign count     = cnt_q;
   assign out_valid = (cnt_q != '0);
   assign instr_out = out_valid ? instr_mem[rd_ptr] : '0;
   assign pc_out    = out_valid ? pc_mem[rd_ptr]    : '0;

   // Redirect outranks both queue operations; pushes only ever land in a
   // slot that was free when the request was launched.
   assign push     = (state == REQ) && mem_ack && !redirect;
   assign pop      = out_valid && out_ready && !redirect;
   assign cnt_next = cnt_q + CW'(push) - CW'(pop);
   assign pc_inc   = fetch_pc + ADDR_W'(PC_STEP);

   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         instr_mem[wr_ptr] <= mem_data;
         pc_mem[wr_ptr]    <= fetch_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt_q    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fetch_pc <= ADDR_W'(RESET_PC);
         mem_re   <= 1'b0;
         mem_addr <= ADDR_W'(RESET_PC);
      end else if (redirect) begin
         cnt_q    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fetch_pc <= redirect_addr;
         // A request still in flight must be drained before issuing the new one.
         if (state != IDLE && !mem_ack) begin
            state <= DROP;
         end else begin
            state    <= REQ;
            mem_re   <= 1'b1;
            mem_addr <= redirect_addr;
         end
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         cnt_q <= cnt_next;
         case (state)
            IDLE: begin
               if (cnt_q < CW'(DEPTH)) begin
                  state    <= REQ;
                  mem_re   <= 1'b1;
                  mem_addr <= fetch_pc;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  fetch_pc <= pc_inc;
                  if (cnt_next < CW'(DEPTH)) begin
                     mem_addr <= pc_inc;
                  end else begin
                     state  <= IDLE;
                     mem_re <= 1'b0;
                  end
               end
            end
            DROP: begin
               if (mem_ack) begin
                  state    <= REQ;
                  mem_addr <= fetch_pc;
               end
            end
            default: begin
               state  <= IDLE;
               mem_re <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: default instance for fetch/flow/redirect cases,
// a DEPTH=8 / ADDR_W=8 instance for address and pointer wrap.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect, mem_ack, out_ready;
   logic [15:0] redirect_addr;
   logic        mem_re, out_valid;
   logic [15:0] mem_addr, mem_data, instr_out, pc_out;
   logic [2:0]  count;

   logic        b_redirect, b_mem_ack, b_out_ready;
   logic [7:0]  b_redirect_addr;
   logic        b_mem_re, b_out_valid;
   logic [7:0]  b_mem_addr, b_pc_out;
   logic [15:0] b_mem_data, b_instr_out;
   logic [3:0]  b_count;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   assign mem_data   = mem_addr ^ 16'hA5A5;
   assign b_mem_data = {8'hC3, b_mem_addr};

   fetch_queue dut (
      .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_addr(redirect_addr),
      .mem_re(mem_re), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
      .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
      .pc_out(pc_out), .count(count)
   );

   fetch_queue #(.DATA_W(16), .ADDR_W(8), .DEPTH(8), .PC_STEP(2), .RESET_PC(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .redirect(b_redirect), .redirect_addr(b_redirect_addr),
      .mem_re(b_mem_re), .mem_addr(b_mem_addr), .mem_ack(b_mem_ack), .mem_data(b_mem_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .instr_out(b_instr_out),
      .pc_out(b_pc_out), .count(b_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      redirect = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] exp_pc;
      redirect = 1'b0; redirect_addr = '0; mem_ack = 1'b1; out_ready = 1'b1;
      b_redirect = 1'b0; b_redirect_addr = '0; b_mem_ack = 1'b0; b_out_ready = 1'b0;

      // Reset state, then full-rate streaming
      rst_n = 1'b0;
      step(); step();
      chk("rst_mem_re", mem_re, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_instr", instr_out, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_count", count, 0);
      rst_n = 1'b1;
      step();
      chk("c1_mem_re", mem_re, 1);
      chk("c1_mem_addr", mem_addr, 16'h0000);
      chk("c1_valid", out_valid, 0);
      step();
      chk("c2_valid", out_valid, 1);
      chk("c2_pc", pc_out, 16'h0000);
      chk("c2_instr", instr_out, 16'hA5A5);
      step();
      chk("c3_pc", pc_out, 16'h0002);
      chk("c3_instr", instr_out, 16'hA5A7);
      chk("c3_count", count, 1);
      step();
      chk("c4_pc", pc_out, 16'h0004);
      step();
      chk("c5_pc", pc_out, 16'h0006);
      chk("c5_instr", instr_out, 16'hA5A3);

      // Backpressure fills the queue, single pop resumes fetch at 8
      out_ready = 1'b0;
      do_reset();
      repeat (5) step();
      chk("full_count", count, 4);
      chk("full_mem_re", mem_re, 0);
      step();
      chk("full_hold_count", count, 4);
      chk("full_hold_mem_re", mem_re, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("pop1_count", count, 3);
      chk("pop1_mem_re", mem_re, 0);
      chk("pop1_pc", pc_out, 16'h0002);
      step();
      chk("refetch_mem_re", mem_re, 1);
      chk("refetch_addr", mem_addr, 16'h0008);
      step();
      chk("refill_count", count, 4);
      chk("refill_mem_re", mem_re, 0);
      // Redirect while idle
      redirect = 1'b1; redirect_addr = 16'h0200;
      step();
      redirect = 1'b0;
      chk("idle_redir_count", count, 0);
      chk("idle_redir_mem_re", mem_re, 1);
      chk("idle_redir_addr", mem_addr, 16'h0200);
      step();
      chk("idle_redir_pc", pc_out, 16'h0200);
      chk("idle_redir_instr", instr_out, 16'hA7A5);

      // Slow memory: 3 cycles without ack per request
      out_ready = 1'b1; mem_ack = 1'b0;
      do_reset();
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("slow0_addr", mem_addr, 16'h0000);
         chk("slow0_mem_re", mem_re, 1);
         chk("slow0_count", count, 0);
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("slow0_pc", pc_out, 16'h0000);
      chk("slow0_instr", instr_out, 16'hA5A5);
      chk("slow0_push_count", count, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("slow1_addr", mem_addr, 16'h0002);
         chk("slow1_count", count, 0);
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("slow1_pc", pc_out, 16'h0002);
      chk("slow1_instr", instr_out, 16'hA5A7);
      chk("slow1_count", count, 1);

      // Redirect with a request to 0x0006 in flight -> DROP
      mem_ack = 1'b1; out_ready = 1'b1;
      do_reset();
      repeat (4) step();
      chk("pre_drop_addr", mem_addr, 16'h0006);
      mem_ack = 1'b0; redirect = 1'b1; redirect_addr = 16'h0080;
      step();
      chk("drop_count", count, 0);
      chk("drop_valid", out_valid, 0);
      chk("drop_mem_re", mem_re, 1);
      chk("drop_addr", mem_addr, 16'h0006);
      redirect_addr = 16'h0100;
      step();
      redirect = 1'b0;
      chk("drop_redir_addr", mem_addr, 16'h0006);
      chk("drop_redir_count", count, 0);
      mem_ack = 1'b1;
      step();
      chk("drop_ack_count", count, 0);
      chk("drop_ack_addr", mem_addr, 16'h0100);
      step();
      chk("post_drop_pc", pc_out, 16'h0100);
      chk("post_drop_instr", instr_out, 16'hA4A5);
      chk("post_drop_count", count, 1);

      // Redirect coincident with ack and pop, count=2
      mem_ack = 1'b1; out_ready = 1'b0;
      do_reset();
      repeat (3) step();
      chk("coin_pre_count", count, 2);
      out_ready = 1'b1; redirect = 1'b1; redirect_addr = 16'h0040;
      step();
      redirect = 1'b0;
      chk("coin_count", count, 0);
      chk("coin_valid", out_valid, 0);
      chk("coin_instr", instr_out, 0);
      chk("coin_pc", pc_out, 0);
      chk("coin_addr", mem_addr, 16'h0040);
      step();
      chk("coin_next_pc", pc_out, 16'h0040);
      chk("coin_next_instr", instr_out, 16'hA5E5);

      // 8-bit address wrap and 8-deep pointer wrap
      mem_ack = 1'b0;
      do_reset();
      step();
      b_redirect = 1'b1; b_redirect_addr = 8'hFE; b_mem_ack = 1'b1; b_out_ready = 1'b0;
      step();
      b_redirect = 1'b0;
      chk("b_redir_addr", b_mem_addr, 8'hFE);
      chk("b_redir_count", b_count, 0);
      step();
      chk("b_wrap_addr", b_mem_addr, 8'h00);
      chk("b_first_pc", b_pc_out, 8'hFE);
      repeat (4) step();
      chk("b_fill_count", b_count, 5);
      b_out_ready = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         step();
         exp_pc = 8'hFE + 8'(2 * j);
         chk("b_stream_pc", b_pc_out, exp_pc);
         chk("b_stream_instr", b_instr_out, {8'hC3, exp_pc});
         chk("b_stream_count", b_count, 5);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
